// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin scheduler sharing one pipelined fp_mul among NREQ requesters.
// Latency: grant/operand mux is combinational; results return tagged LAT clocks after issue.
// Backpressure: req_ready is one-hot on the granted requester; results have none. Optional FP_MUL_ARB_STATS_EN adds an issue counter.
module fp_mul_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LAT   = 4,
  parameter int ID_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef FP_MUL_ARB_STATS_EN
  input  logic                        stat_clr,
  output logic [31:0]                 stat_issue_cnt,
`endif
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*WIDTH-1:0]       req_a,
  input  logic [NREQ*WIDTH-1:0]       req_b,
  input  logic [NREQ*3-1:0]           req_rm,
  output logic [WIDTH-1:0]            mul_a,
  output logic [WIDTH-1:0]            mul_b,
  output logic [2:0]                  mul_rm,
  input  logic [WIDTH-1:0]            mul_result,
  output logic                        res_valid,
  output logic [ID_W-1:0]             res_id,
  output logic [WIDTH-1:0]            res_data,
  input  logic                        drain_req,
  output logic                        idle,
  output logic [$clog2(LAT+1)-1:0]    inflight
);

  localparam int CNT_W = $clog2(LAT+1);
  localparam logic [ID_W:0]   NREQ_X  = (ID_W+1)'(NREQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ-1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t             r_state;
  logic               r_idle;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [LAT-1:0]     r_tag_vld;
  logic [ID_W-1:0]    r_tag_id [LAT];
  logic [CNT_W-1:0]   r_inflight;

  logic [2*NREQ-1:0]  w_dbl;
  logic [NREQ-1:0]    w_rot;
  logic               w_found;
  logic [ID_W-1:0]    w_off;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_can_grant;
  logic               w_issue;
  logic [NREQ-1:0]    w_grant;

  // Grants are suppressed outside RUN and in the very cycle drain is requested.
  assign w_can_grant = (r_state == ST_RUN) && !drain_req;

  // Rotate the request vector so bit 0 is the requester at rr_ptr.
  assign w_dbl = {req_valid, req_valid};
  assign w_rot = w_dbl[r_rr_ptr +: NREQ];

  // Find the lowest set bit of the rotated vector (offset from rr_ptr).
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = ID_W'(k);
      end
    end
  end

  // Map the offset back to an absolute requester index, wrapping at NREQ.
  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_gnt_id = (w_sum >= NREQ_X) ? ID_W'(w_sum - NREQ_X) : w_sum[ID_W-1:0];
  assign w_issue  = w_found && w_can_grant;
  assign w_grant  = w_issue ? (NREQ'(1) << w_gnt_id) : '0;
  assign req_ready = w_grant;

  // Operand mux: OR of the one-hot-selected lanes, all-zero with no grant.
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    mul_rm = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        mul_a  = mul_a  | req_a[i*WIDTH +: WIDTH];
        mul_b  = mul_b  | req_b[i*WIDTH +: WIDTH];
        mul_rm = mul_rm | req_rm[i*3 +: 3];
      end
    end
  end

  // Round-robin pointer moves just past the requester that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  // Tag pipe tracks {valid, id} alongside the multiplier's internal stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int i = 0; i < LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_vld[0] <= w_issue;
      r_tag_id[0]  <= w_gnt_id;
      for (int i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  // In-flight count: up on issue, down when a tagged result leaves the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(r_tag_vld[LAT-1]);
    end
  end

  // Drain FSM with registered idle flag mirroring the HALTED state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_idle  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_idle <= 1'b0;
          if (drain_req) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!drain_req) begin
            r_state <= ST_RUN;
            r_idle  <= 1'b0;
          end else if (r_inflight == '0) begin
            r_state <= ST_HALTED;
            r_idle  <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!drain_req) begin
            r_state <= ST_RUN;
            r_idle  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_idle  <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = r_tag_vld[LAT-1];
  assign res_id    = r_tag_id[LAT-1];
  assign res_data  = mul_result;
  assign idle      = r_idle;
  assign inflight  = r_inflight;

`ifdef FP_MUL_ARB_STATS_EN
  logic [31:0] r_stat_cnt;

  // Saturating issue counter; a clear wins over a coincident issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_cnt <= '0;
    end else if (stat_clr) begin
      r_stat_cnt <= '0;
    end else if (w_issue && (r_stat_cnt != 32'hFFFF_FFFF)) begin
      r_stat_cnt <= r_stat_cnt + 32'd1;
    end
  end

  assign stat_issue_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Testbench for fp_mul_arbiter: directed phases plus random traffic checked against
// a cycle-indexed issue history model; the multiplier is emulated as a LAT-deep pipe.
module tb_fp_mul_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int LAT   = 4;
  localparam int ID_W  = 2;
  localparam int CW    = $clog2(LAT+1);
  localparam int HMAX  = 4096;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*WIDTH-1:0]  req_a;
  logic [NREQ*WIDTH-1:0]  req_b;
  logic [NREQ*3-1:0]      req_rm;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic [2:0]             mul_rm;
  logic [WIDTH-1:0]       mul_result;
  logic                   res_valid;
  logic [ID_W-1:0]        res_id;
  logic [WIDTH-1:0]       res_data;
  logic                   drain_req;
  logic                   idle;
  logic [CW-1:0]          inflight;
`ifdef FP_MUL_ARB_STATS_EN
  logic                   stat_clr;
  logic [31:0]            stat_issue_cnt;
`endif

  fp_mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FP_MUL_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_issue_cnt(stat_issue_cnt),
`endif
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm), .mul_result(mul_result),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .drain_req(drain_req), .idle(idle), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in multiplier: any deterministic function, registered LAT deep.
  function automatic logic [WIDTH-1:0] fmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [2:0] rm);
    logic [2*WIDTH-1:0] p;
    p = a * b;
    return p[WIDTH-1:0] ^ {{(WIDTH-3){1'b0}}, rm} ^ 16'h5A5A;
  endfunction

  logic [WIDTH-1:0] fm [LAT];
  always @(posedge clk) begin
    fm[0] <= fmul(mul_a, mul_b, mul_rm);
    for (int i = 1; i < LAT; i++) fm[i] <= fm[i-1];
  end
  assign mul_result = fm[LAT-1];

  // Reference model state
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_ptr  = 0;
  int m_st   = 0;            // 0 run, 1 drain, 2 halted
  longint m_cnt = 0;
  bit              h_vld [HMAX];
  int              h_id  [HMAX];
  logic [WIDTH-1:0] h_dat [HMAX];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Operations issued in the last LAT edges are still inside the multiplier.
  function automatic int model_inflight();
    int n;
    n = 0;
    for (int e = cyc - LAT + 1; e <= cyc; e++)
      if (e >= 0 && h_vld[e]) n++;
    return n;
  endfunction

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] rm);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_rm[i*3 +: 3]        = rm;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++)
      set_op(i, WIDTH'($urandom), WIDTH'($urandom), 3'($urandom));
  endtask

  // One clock: check combinational grant, clock it, update the model, check registered outputs.
  task automatic tick();
    int g;
    int infl_before;
    int e;
    bit exp_v;
    logic [NREQ-1:0]  eready;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [2:0]       erm;
    #1;
    g = -1;
    if (m_st == 0 && !drain_req) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    eready = '0; ea = '0; eb = '0; erm = '0;
    if (g >= 0) begin
      eready[g] = 1'b1;
      ea  = req_a[g*WIDTH +: WIDTH];
      eb  = req_b[g*WIDTH +: WIDTH];
      erm = req_rm[g*3 +: 3];
    end
    chk("req_ready", req_ready, eready);
    chk("mul_a", mul_a, ea);
    chk("mul_b", mul_b, eb);
    chk("mul_rm", mul_rm, erm);
    infl_before = model_inflight();
    @(posedge clk);
    cyc++;
    h_vld[cyc] = (g >= 0);
    h_id[cyc]  = (g >= 0) ? g : 0;
    h_dat[cyc] = fmul(ea, eb, erm);
    if (g >= 0) m_ptr = (g + 1) % NREQ;
`ifdef FP_MUL_ARB_STATS_EN
    if (stat_clr) m_cnt = 0;
    else if (g >= 0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
`endif
    case (m_st)
      0: if (drain_req) m_st = 1;
      1: if (!drain_req) m_st = 0; else if (infl_before == 0) m_st = 2;
      default: if (!drain_req) m_st = 0;
    endcase
    #1;
    e = cyc - LAT + 1;
    exp_v = (e >= 0) ? h_vld[e] : 1'b0;
    chk("res_valid", res_valid, exp_v);
    if (exp_v) begin
      chk("res_id", res_id, h_id[e]);
      chk("res_data", res_data, h_dat[e]);
    end
    chk("inflight", inflight, model_inflight());
    chk("idle", idle, m_st == 2);
`ifdef FP_MUL_ARB_STATS_EN
    chk("stat_issue_cnt", stat_issue_cnt, m_cnt);
`endif
  endtask

  task automatic do_reset();
    req_valid = '0;
    drain_req = 1'b0;
`ifdef FP_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_id", res_id, '0);
    chk("rst_idle", idle, 1'b0);
    chk("rst_inflight", inflight, '0);
    chk("rst_req_ready", req_ready, '0);
`ifdef FP_MUL_ARB_STATS_EN
    chk("rst_stat_cnt", stat_issue_cnt, '0);
`endif
    m_ptr = 0;
    m_st  = 0;
    m_cnt = 0;
    for (int i = 0; i <= cyc; i++) h_vld[i] = 1'b0;
    @(posedge clk);
    cyc++;
    h_vld[cyc] = 1'b0;
    #2 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_a = '0; req_b = '0; req_rm = '0;
    drain_req = 1'b0;
`ifdef FP_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    do_reset();

    // Single requester 2 streaming 1.0 * 2.0
    set_op(2, 16'h3C00, 16'h4000, 3'd0);
    req_valid = 4'b0100;
    for (int n = 0; n < 12; n++) tick();
    req_valid = '0;
    for (int n = 0; n < LAT + 1; n++) tick();

    // All requesters valid: strict rotation
    req_valid = 4'b1111;
    for (int n = 0; n < 16; n++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    for (int n = 0; n < LAT + 1; n++) tick();

    // Park the pointer at 2, then requesters 1 and 3 contend
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    for (int n = 0; n < 6; n++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    for (int n = 0; n < LAT + 1; n++) tick();

    // Three back-to-back issues, then drain to HALTED and resume
    req_valid = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      rand_ops();
      tick();
    end
    req_valid = 4'b1111;
    drain_req = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    drain_req = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    req_valid = '0;
    for (int n = 0; n < LAT + 1; n++) tick();

    // Two issues then a reset pulse: their results must never surface
    req_valid = 4'b1000;
    for (int n = 0; n < 2; n++) begin
      rand_ops();
      tick();
    end
    do_reset();
    for (int n = 0; n < LAT + 2; n++) tick();
    req_valid = 4'b1111;
    for (int n = 0; n < 3; n++) tick();

    // Random traffic with operands churning and occasional drain
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      rand_ops();
      if ($urandom_range(0, 9) == 0) drain_req = ~drain_req;
`ifdef FP_MUL_ARB_STATS_EN
      stat_clr = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end
    drain_req = 1'b0;
    req_valid = '0;
`ifdef FP_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int n = 0; n < LAT + 2; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
